// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: latches decoded ops, resolves rs/rt bypass, selects immediate, detects load-use hazards.
// Define EX_FWD_EN to enable the EX/MEM bypass network; otherwise ID stalls until producers retire.
module ex_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int IMMW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [2:0]      id_alu_op,
  input  logic [DW-1:0]   id_rs_val,
  input  logic [DW-1:0]   id_rt_val,
  input  logic [AW-1:0]   id_rs_addr,
  input  logic [AW-1:0]   id_rt_addr,
  input  logic [IMMW-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_imm_sext,
  input  logic [AW-1:0]   id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [DW-1:0]   alu_result,
  input  logic            mem_reg_write,
  input  logic [AW-1:0]   mem_rd_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic [2:0]      ALU_OP,
  output logic [DW-1:0]   rs,
  output logic [DW-1:0]   rt,
  output logic            ex_valid,
  output logic [AW-1:0]   ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_illegal,
  output logic            id_stall
);

  logic [DW-1:0] imm_ext;
  logic [DW-1:0] rs_byp;
  logic [DW-1:0] rt_byp;
  logic          hazard;

  assign imm_ext = id_imm_sext ? {{(DW-IMMW){id_imm[IMMW-1]}}, id_imm}
                               : {{(DW-IMMW){1'b0}}, id_imm};

`ifdef EX_FWD_EN
  logic ex_fwd;
  logic mem_fwd;

  // A load in this stage has no data yet, so it never feeds alu_result forward.
  assign ex_fwd  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd_addr != '0);
  assign mem_fwd = mem_reg_write & (mem_rd_addr != '0);

  always_comb begin
    rs_byp = id_rs_val;
    if (ex_fwd && ex_rd_addr == id_rs_addr)        rs_byp = alu_result;
    else if (mem_fwd && mem_rd_addr == id_rs_addr) rs_byp = mem_data;
    rt_byp = id_rt_val;
    if (ex_fwd && ex_rd_addr == id_rt_addr)        rt_byp = alu_result;
    else if (mem_fwd && mem_rd_addr == id_rt_addr) rt_byp = mem_data;
  end

  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd_addr != '0) &
                  ((ex_rd_addr == id_rs_addr) | ((ex_rd_addr == id_rt_addr) & ~id_use_imm));
`else
  logic ex_wr;
  logic mem_wr;
  logic unused_fwd;

  assign unused_fwd = ^{alu_result, mem_data};
  assign rs_byp     = id_rs_val;
  assign rt_byp     = id_rt_val;
  assign ex_wr      = ex_valid & ex_reg_write & (ex_rd_addr != '0);
  assign mem_wr     = mem_reg_write & (mem_rd_addr != '0);

  // Without bypass, any in-flight writer of a used source blocks ID until it reaches the regfile.
  assign hazard = id_valid & (
                  (ex_wr  & ((ex_rd_addr  == id_rs_addr) | ((ex_rd_addr  == id_rt_addr) & ~id_use_imm))) |
                  (mem_wr & ((mem_rd_addr == id_rs_addr) | ((mem_rd_addr == id_rt_addr) & ~id_use_imm))));
`endif

  assign id_stall = ex_hold | hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_OP       <= '0;
      rs           <= '0;
      rt           <= '0;
      ex_valid     <= 1'b0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!ex_hold) begin
      if (flush || hazard || !id_valid) begin
        ALU_OP       <= '0;
        rs           <= '0;
        rt           <= '0;
        ex_valid     <= 1'b0;
        ex_rd_addr   <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_illegal   <= 1'b0;
      end else begin
        ALU_OP       <= (id_alu_op == 3'b111) ? 3'b000 : id_alu_op;
        rs           <= rs_byp;
        rt           <= id_use_imm ? imm_ext : rt_byp;
        ex_valid     <= 1'b1;
        ex_rd_addr   <= id_rd_addr;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_illegal   <= (id_alu_op == 3'b111);
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed instructions push expected stage contents,
// a negedge monitor compares each newly presented instruction (or bubble) against the queue.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_imm, id_imm_sext, id_reg_write, id_mem_read;
  logic [2:0]  id_alu_op;
  logic [31:0] id_rs_val, id_rt_val, alu_result, mem_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr;
  logic [15:0] id_imm;
  logic        mem_reg_write, ex_hold, flush;
  logic [2:0]  ALU_OP;
  logic [31:0] rs, rt;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_illegal, id_stall;
  logic [4:0]  ex_rd_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];
  out_t last = '0;
  logic held = 1'b0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_imm_sext(id_imm_sext), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .alu_result(alu_result), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_data(mem_data), .ex_hold(ex_hold), .flush(flush),
    .ALU_OP(ALU_OP), .rs(rs), .rt(rt), .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_illegal(ex_illegal),
    .id_stall(id_stall)
  );

  always #5 clk = ~clk;

  function automatic out_t cur();
    return {ex_valid, ALU_OP, rs, rt, ex_rd_addr, ex_reg_write, ex_mem_read, ex_illegal};
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b op=%h rs=%h rt=%h rd=%0d rw=%b mr=%b ill=%b, expected v=%b op=%h rs=%h rt=%h rd=%0d rw=%b mr=%b ill=%b",
               name, act.v, act.op, act.rs, act.rt, act.rd, act.rw, act.mr, act.ill,
               exp.v, exp.op, exp.rs, exp.rt, exp.rd, exp.rw, exp.mr, exp.ill);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: a held edge must leave the stage untouched; otherwise a valid stage pops the queue.
  always @(posedge clk) held = rst ? 1'b0 : ex_hold;

  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        check_out("hold_keeps_state", cur(), last);
      end else if (ex_valid) begin
        if (exp_q.size() == 0) begin
          check_out("unexpected_instr", cur(), '0);
          last = cur();
        end else begin
          last = exp_q.pop_front();
          check_out("instr", cur(), last);
        end
      end else begin
        last = '0;
        check_out("bubble", cur(), '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rd, input logic [31:0] va, input logic [31:0] vb,
                        input logic rw, input logic mr, input logic ui, input logic sx,
                        input logic [15:0] imm);
    id_valid = 1'b1; id_alu_op = op; id_rs_addr = ra; id_rt_addr = rb; id_rd_addr = rd;
    id_rs_val = va; id_rt_val = vb; id_reg_write = rw; id_mem_read = mr;
    id_use_imm = ui; id_imm_sext = sx; id_imm = imm;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic ill);
    out_t e;
    e = {1'b1, op, a, b, rd, rw, mr, ill};
    exp_q.push_back(e);
  endtask

  task automatic stall_is(input string name, input logic exp);
    #1;
    check_bit(name, id_stall, exp);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_alu_op = '0; id_rs_val = '0; id_rt_val = '0;
    id_rs_addr = '0; id_rt_addr = '0; id_imm = '0; id_use_imm = 1'b0; id_imm_sext = 1'b0;
    id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; alu_result = '0;
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_data = '0; ex_hold = 1'b0; flush = 1'b0;
    #3;
    check_out("reset_state", cur(), '0);
    step();
    step();
    rst = 1'b0;

    // Reset asserted mid-cycle clears a valid stage at once; next capture proceeds normally.
    set_id(3'b001, 5'd1, 5'd2, 5'd20, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    push(3'b001, 32'h1, 32'h2, 5'd20, 1'b1, 1'b0, 1'b0);
    step();
    set_id(3'b010, 5'd1, 5'd2, 5'd3, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    #6 rst = 1'b1;
    #1 check_out("reset_async", cur(), '0);
    #1 rst = 1'b0;
    push(3'b010, 32'h3, 32'h4, 5'd3, 1'b1, 1'b0, 1'b0);
    step();

    // add r3 in EX, sub r4<-r3,r5 follows.
    alu_result = 32'h7;
    set_id(3'b101, 5'd3, 5'd5, 5'd4, 32'h11, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef EX_FWD_EN
    stall_is("raw_ex_no_stall", 1'b0);
    push(3'b101, 32'h7, 32'h55, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
`else
    stall_is("raw_ex_stall1", 1'b1);
    step();
    alu_result = '0; mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_data = 32'h7;
    stall_is("raw_mem_stall2", 1'b1);
    step();
    mem_reg_write = 1'b0; id_rs_val = 32'h7;
    stall_is("raw_cleared", 1'b0);
    push(3'b101, 32'h7, 32'h55, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
`endif

    // lw r8, 4(r1) then or r9<-r8,r8.
    alu_result = 32'h1234;
    set_id(3'b010, 5'd1, 5'd0, 5'd8, 32'h100, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004);
    stall_is("lw_no_stall", 1'b0);
    push(3'b010, 32'h100, 32'h4, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    alu_result = 32'h104;
    set_id(3'b001, 5'd8, 5'd8, 5'd9, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    stall_is("load_use_stall", 1'b1);
    step();
    alu_result = '0; mem_reg_write = 1'b1; mem_rd_addr = 5'd8; mem_data = 32'hDEAD_BEEF;
`ifdef EX_FWD_EN
    stall_is("load_use_cleared", 1'b0);
`else
    stall_is("load_mem_stall", 1'b1);
    step();
    mem_reg_write = 1'b0; id_rs_val = 32'hDEAD_BEEF; id_rt_val = 32'hDEAD_BEEF;
    stall_is("load_use_cleared", 1'b0);
`endif
    push(3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0);
    step();

    // Immediate extension; rt_addr matches r9 in EX but is unused.
    mem_reg_write = 1'b0;
    set_id(3'b000, 5'd10, 5'd9, 5'd13, 32'h10, 32'h99, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8000);
    stall_is("imm_rt_unused", 1'b0);
    push(3'b000, 32'h10, 32'hFFFF_8000, 5'd13, 1'b1, 1'b0, 1'b0);
    step();
    set_id(3'b000, 5'd11, 5'd0, 5'd14, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000);
    push(3'b000, 32'h20, 32'h0000_8000, 5'd14, 1'b1, 1'b0, 1'b0);
    step();

    // Flush kills the capture; then hold (with and without flush) freezes the stage.
    set_id(3'b001, 5'd1, 5'd2, 5'd15, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_id(3'b100, 5'd1, 5'd2, 5'd15, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    push(3'b100, 32'h1, 32'h2, 5'd15, 1'b1, 1'b0, 1'b0);
    step();
    ex_hold = 1'b1; flush = 1'b1;
    set_id(3'b011, 5'd3, 5'd4, 5'd16, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    stall_is("hold_flush_stall", 1'b1);
    step();
    flush = 1'b0;
    stall_is("hold_stall", 1'b1);
    step();
    ex_hold = 1'b0;
    set_id(3'b011, 5'd2, 5'd3, 5'd0, 32'h22, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    stall_is("after_hold", 1'b0);
    push(3'b011, 32'h22, 32'h33, 5'd0, 1'b1, 1'b0, 1'b0);
    step();

    // r0 writers in EX and MEM must neither bypass nor stall a reader of r0.
    alu_result = 32'hBAD; mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_data = 32'hBAD1;
    set_id(3'b100, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    stall_is("r0_no_stall", 1'b0);
    push(3'b100, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    mem_reg_write = 1'b0; alu_result = '0;
    set_id(3'b111, 5'd7, 5'd0, 5'd5, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    push(3'b000, 32'h77, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
    step();

    id_valid = 1'b0;
    repeat (3) step();
    check_bit("queue_drained", exp_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
